// File: rtl/reg_arb_pkg.sv
// Shared types and sizing helpers for the register-master arbiter.
package reg_arb_pkg;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT_ACK} arb_state_e;

  // Counter width for a given timeout; a disabled timeout still gets one bit.
  function automatic int unsigned tmo_width(input int unsigned cyc);
    return (cyc == 0) ? 1 : $clog2(cyc + 1);
  endfunction

  localparam int unsigned DEF_TIMEOUT_CYC = 256;
  localparam int unsigned TMO_W = tmo_width(DEF_TIMEOUT_CYC);

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned IDX_W = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   idx
);

  logic             found;
  logic [IDX_W-1:0] cand;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      cand = IDX_W'((32'(ptr) + off) % NUM_REQ);
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/reg_mst_arbiter.sv
// Round-robin sharing of one register-slave master port among NUM_REQ requesters,
// one transaction in flight, with timeout abort and error response.
module reg_mst_arbiter
  import reg_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 64,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned TIMEOUT_CYC = 256,
  parameter logic [DATA_WIDTH-1:0] ERR_DATA = DATA_WIDTH'(32'hDEAD_BEEF)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req__arb__req_vld,
  input  logic [NUM_REQ-1:0]            req__arb__rd_en,
  input  logic [NUM_REQ-1:0]            req__arb__wr_en,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req__arb__addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req__arb__wr_data,
  input  logic [NUM_REQ-1:0]            req__arb__ack_rdy,
  output logic [NUM_REQ-1:0]            arb__req__req_rdy,
  output logic [NUM_REQ-1:0]            arb__req__ack_vld,
  output logic [DATA_WIDTH-1:0]         arb__req__rd_data,
  output logic [NUM_REQ-1:0]            arb__req__err,
  output logic                          arb__fsm__req_vld,
  output logic                          arb__fsm__rd_en,
  output logic                          arb__fsm__wr_en,
  output logic [ADDR_WIDTH-1:0]         arb__fsm__addr,
  output logic [DATA_WIDTH-1:0]         arb__fsm__wr_data,
  output logic                          arb__fsm__ack_rdy,
  output logic                          arb__fsm__sync_reset,
  input  logic                          fsm__arb__req_rdy,
  input  logic                          fsm__arb__ack_vld,
  input  logic [DATA_WIDTH-1:0]         fsm__arb__rd_data
);

  localparam int unsigned IDX_W  = $clog2(NUM_REQ);
  localparam int unsigned TMO_CW = tmo_width(TIMEOUT_CYC);
  localparam logic [TMO_CW-1:0] TMO_LAST = TMO_CW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  arb_state_e          state_q, state_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic [IDX_W-1:0]    gidx_q, gidx_d;
  logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [TMO_CW-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic                abort_q, abort_d;

  logic [NUM_REQ-1:0]  pick_gnt;
  logic [IDX_W-1:0]    pick_idx;
  logic [IDX_W-1:0]    next_ptr;
  logic                complete;
  logic                abort;
  logic                busy;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .req (req__arb__req_vld),
    .ptr (rr_ptr_q),
    .gnt (pick_gnt),
    .idx (pick_idx)
  );

  assign next_ptr = (gidx_q == IDX_W'(NUM_REQ - 1)) ? '0 : gidx_q + 1'b1;

  always_comb begin
    state_d           = state_q;
    grant_d           = grant_q;
    gidx_d            = gidx_q;
    rr_ptr_d          = rr_ptr_q;
    tmo_cnt_d         = tmo_cnt_q;
    complete          = 1'b0;
    abort             = 1'b0;
    arb__req__req_rdy = '0;
    arb__fsm__req_vld = 1'b0;
    arb__fsm__ack_rdy = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (|req__arb__req_vld) begin
          grant_d = pick_gnt;
          gidx_d  = pick_idx;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        arb__fsm__req_vld = 1'b1;
        if (fsm__arb__req_rdy) begin
          arb__req__req_rdy = grant_q;
          if (fsm__arb__ack_vld) complete = 1'b1;
          else                   state_d  = S_WAIT_ACK;
        end
      end
      S_WAIT_ACK: begin
        arb__fsm__ack_rdy = req__arb__ack_rdy[gidx_q];
        tmo_cnt_d         = tmo_cnt_q + 1'b1;
        if (fsm__arb__ack_vld) begin
          complete = 1'b1;
        end else if ((TIMEOUT_CYC > 0) && (tmo_cnt_q == TMO_LAST)) begin
          abort = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Both completion kinds release the port and advance the pointer past the winner.
    if (complete || abort) begin
      state_d   = S_IDLE;
      grant_d   = '0;
      gidx_d    = '0;
      tmo_cnt_d = '0;
      rr_ptr_d  = next_ptr;
    end
    abort_d = abort;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      grant_q   <= '0;
      gidx_q    <= '0;
      rr_ptr_q  <= '0;
      tmo_cnt_q <= '0;
      abort_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      gidx_q    <= gidx_d;
      rr_ptr_q  <= rr_ptr_d;
      tmo_cnt_q <= tmo_cnt_d;
      abort_q   <= abort_d;
    end
  end

  assign busy = (state_q != S_IDLE);

  assign arb__fsm__rd_en      = busy & req__arb__rd_en[gidx_q];
  assign arb__fsm__wr_en      = busy & req__arb__wr_en[gidx_q];
  assign arb__fsm__addr       = busy ? req__arb__addr[gidx_q*ADDR_WIDTH +: ADDR_WIDTH] : '0;
  assign arb__fsm__wr_data    = busy ? req__arb__wr_data[gidx_q*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign arb__fsm__sync_reset = abort_q;

  assign arb__req__ack_vld = grant_q & {NUM_REQ{complete | abort}};
  assign arb__req__err     = grant_q & {NUM_REQ{abort}};
  assign arb__req__rd_data = abort ? ERR_DATA : (complete ? fsm__arb__rd_data : '0);

endmodule

// File: tb/tb_reg_mst_arbiter.sv
// Directed self-checking bench for reg_mst_arbiter (4 requesters, 8-cycle timeout).
module tb_reg_mst_arbiter;

  localparam int unsigned NR = 4;
  localparam int unsigned AW = 64;
  localparam int unsigned DW = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic [NR-1:0]    req_vld, rd_en, wr_en, ack_rdy_in;
  logic [NR*AW-1:0] addr;
  logic [NR*DW-1:0] wr_data;
  logic [NR-1:0]    req_rdy, ack_vld, err;
  logic [DW-1:0]    rd_data;
  logic             f_req_vld, f_rd_en, f_wr_en, f_ack_rdy, f_sync_reset;
  logic [AW-1:0]    f_addr;
  logic [DW-1:0]    f_wr_data;
  logic             f_req_rdy, f_ack_vld;
  logic [DW-1:0]    f_rd_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reg_mst_arbiter #(
    .ADDR_WIDTH  (AW),
    .DATA_WIDTH  (DW),
    .NUM_REQ     (NR),
    .TIMEOUT_CYC (8)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .req__arb__req_vld    (req_vld),
    .req__arb__rd_en      (rd_en),
    .req__arb__wr_en      (wr_en),
    .req__arb__addr       (addr),
    .req__arb__wr_data    (wr_data),
    .req__arb__ack_rdy    (ack_rdy_in),
    .arb__req__req_rdy    (req_rdy),
    .arb__req__ack_vld    (ack_vld),
    .arb__req__rd_data    (rd_data),
    .arb__req__err        (err),
    .arb__fsm__req_vld    (f_req_vld),
    .arb__fsm__rd_en      (f_rd_en),
    .arb__fsm__wr_en      (f_wr_en),
    .arb__fsm__addr       (f_addr),
    .arb__fsm__wr_data    (f_wr_data),
    .arb__fsm__ack_rdy    (f_ack_rdy),
    .arb__fsm__sync_reset (f_sync_reset),
    .fsm__arb__req_rdy    (f_req_rdy),
    .fsm__arb__ack_vld    (f_ack_vld),
    .fsm__arb__rd_data    (f_rd_data)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_inputs();
    req_vld    = '0;
    rd_en      = '0;
    wr_en      = '0;
    ack_rdy_in = '0;
    addr       = '0;
    wr_data    = '0;
    f_req_rdy  = 1'b0;
    f_ack_vld  = 1'b0;
    f_rd_data  = '0;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, ".fsm_req_vld"}, 64'(f_req_vld), 64'h0);
    chk({tag, ".fsm_rd_en"}, 64'(f_rd_en), 64'h0);
    chk({tag, ".fsm_wr_en"}, 64'(f_wr_en), 64'h0);
    chk({tag, ".fsm_addr"}, 64'(f_addr), 64'h0);
    chk({tag, ".fsm_wr_data"}, 64'(f_wr_data), 64'h0);
    chk({tag, ".fsm_ack_rdy"}, 64'(f_ack_rdy), 64'h0);
    chk({tag, ".sync_reset"}, 64'(f_sync_reset), 64'h0);
    chk({tag, ".req_rdy"}, 64'(req_rdy), 64'h0);
    chk({tag, ".ack_vld"}, 64'(ack_vld), 64'h0);
    chk({tag, ".err"}, 64'(err), 64'h0);
    chk({tag, ".rd_data"}, 64'(rd_data), 64'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    chk_quiet("reset");
    rst = 1'b0;

    // Spurious downstream ack while idle must not be forwarded.
    f_ack_vld = 1'b1;
    f_rd_data = 32'h1111_2222;
    settle();
    chk("spur.ack_vld", 64'(ack_vld), 64'h0);
    chk("spur.rd_data", 64'(rd_data), 64'h0);
    tick();
    clear_inputs();
    settle();
    chk("spur.idle", 64'(f_req_vld), 64'h0);

    // Test 1: single write from requester 2 (rr_ptr=0).
    req_vld[2] = 1'b1;
    wr_en[2] = 1'b1;
    addr[2*AW +: AW] = 64'h40;
    wr_data[2*DW +: DW] = 32'h1234_5678;
    settle();
    chk("t1.latency", 64'(f_req_vld), 64'h0);
    tick();
    chk("t1.req_vld", 64'(f_req_vld), 64'h1);
    chk("t1.addr", 64'(f_addr), 64'h40);
    chk("t1.wr_en", 64'(f_wr_en), 64'h1);
    chk("t1.rd_en", 64'(f_rd_en), 64'h0);
    chk("t1.wr_data", 64'(f_wr_data), 64'h1234_5678);
    chk("t1.no_rdy", 64'(req_rdy), 64'h0);
    tick();
    f_req_rdy = 1'b1;
    settle();
    chk("t1.req_rdy", 64'(req_rdy), 64'h4);
    tick();
    f_req_rdy = 1'b0;
    req_vld = '0;
    settle();
    chk("t1.wait_rdy", 64'(req_rdy), 64'h0);
    chk("t1.wait_ack", 64'(ack_vld), 64'h0);
    chk("t1.wait_vld", 64'(f_req_vld), 64'h0);
    tick();
    f_ack_vld = 1'b1;
    settle();
    chk("t1.ack_vld", 64'(ack_vld), 64'h4);
    chk("t1.err", 64'(err), 64'h0);
    tick();
    clear_inputs();
    settle();
    chk("t1.idle_vld", 64'(f_req_vld), 64'h0);
    chk("t1.idle_addr", 64'(f_addr), 64'h0);

    // Test 3: read from requester 1 (rr_ptr=3, wraps to 1).
    req_vld[1] = 1'b1;
    rd_en[1] = 1'b1;
    addr[1*AW +: AW] = 64'h80;
    settle();
    tick();
    f_req_rdy = 1'b1;
    settle();
    chk("t3.req_rdy", 64'(req_rdy), 64'h2);
    chk("t3.rd_en", 64'(f_rd_en), 64'h1);
    chk("t3.addr", 64'(f_addr), 64'h80);
    tick();
    f_req_rdy = 1'b0;
    req_vld = '0;
    ack_rdy_in[1] = 1'b1;
    settle();
    chk("t3.ack_rdy", 64'(f_ack_rdy), 64'h1);
    chk("t3.no_ack", 64'(ack_vld), 64'h0);
    tick();
    f_ack_vld = 1'b1;
    f_rd_data = 32'hA5A5_0001;
    settle();
    chk("t3.ack_vld", 64'(ack_vld), 64'h2);
    chk("t3.rd_data", 64'(rd_data), 64'hA5A5_0001);
    tick();
    clear_inputs();
    settle();
    chk("t3.after_ack", 64'(ack_vld), 64'h0);
    chk("t3.after_data", 64'(rd_data), 64'h0);

    // Test 5: requester 3 (rr_ptr=2), req_rdy and ack in the same REQ cycle.
    req_vld[3] = 1'b1;
    wr_en[3] = 1'b1;
    addr[3*AW +: AW] = 64'hC0;
    settle();
    tick();
    f_req_rdy = 1'b1;
    f_ack_vld = 1'b1;
    f_rd_data = 32'h55;
    settle();
    chk("t5.req_rdy", 64'(req_rdy), 64'h8);
    chk("t5.ack_vld", 64'(ack_vld), 64'h8);
    tick();
    clear_inputs();
    settle();
    chk("t5.idle_vld", 64'(f_req_vld), 64'h0);
    chk("t5.idle_ack", 64'(ack_vld), 64'h0);

    // Test 2: all requesters valid, immediate acks; expect 0,1,2,3,0.
    req_vld = 4'hF;
    wr_en = 4'hF;
    for (int i = 0; i < 4; i++) addr[i*AW +: AW] = 64'h100 + 64'(i);
    f_req_rdy = 1'b1;
    f_ack_vld = 1'b1;
    settle();
    chk("t2.idle0", 64'(ack_vld), 64'h0);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("t2.ack%0d", k), 64'(ack_vld), 64'h1 << (k % 4));
      chk($sformatf("t2.addr%0d", k), 64'(f_addr), 64'h100 + 64'(k % 4));
      tick();
      chk($sformatf("t2.idle%0d", k + 1), 64'(ack_vld), 64'h0);
    end
    clear_inputs();

    // Test 4: requester 0 (rr_ptr=1, wraps to 0), no ack -> timeout after 8 cycles.
    req_vld[0] = 1'b1;
    rd_en[0] = 1'b1;
    addr[0 +: AW] = 64'h200;
    settle();
    tick();
    f_req_rdy = 1'b1;
    settle();
    chk("t4.req_rdy", 64'(req_rdy), 64'h1);
    tick();
    f_req_rdy = 1'b0;
    req_vld = '0;
    settle();
    for (int w = 0; w < 7; w++) begin
      chk($sformatf("t4.wait%0d", w), 64'(ack_vld), 64'h0);
      tick();
    end
    chk("t4.ack_vld", 64'(ack_vld), 64'h1);
    chk("t4.err", 64'(err), 64'h1);
    chk("t4.rd_data", 64'(rd_data), 64'hDEAD_BEEF);
    chk("t4.sync_early", 64'(f_sync_reset), 64'h0);
    tick();
    chk("t4.sync", 64'(f_sync_reset), 64'h1);
    chk("t4.ack_after", 64'(ack_vld), 64'h0);
    chk("t4.err_after", 64'(err), 64'h0);
    chk("t4.idle", 64'(f_req_vld), 64'h0);
    tick();
    chk("t4.sync_once", 64'(f_sync_reset), 64'h0);
    clear_inputs();

    // Test 6: reset while waiting for ack from requester 2 (rr_ptr=1).
    req_vld[2] = 1'b1;
    wr_en[2] = 1'b1;
    addr[2*AW +: AW] = 64'h300;
    settle();
    tick();
    f_req_rdy = 1'b1;
    settle();
    chk("t6.req_rdy", 64'(req_rdy), 64'h4);
    tick();
    clear_inputs();
    rst = 1'b1;
    settle();
    chk("t6.no_ack", 64'(ack_vld), 64'h0);
    tick();
    rst = 1'b0;
    settle();
    chk_quiet("t6.post_rst");
    // Pointer back at 0: with 0 and 1 both requesting, 0 must win.
    req_vld = 4'b0011;
    rd_en = 4'b0011;
    addr[0 +: AW] = 64'h10;
    addr[1*AW +: AW] = 64'h20;
    settle();
    tick();
    f_req_rdy = 1'b1;
    f_ack_vld = 1'b1;
    settle();
    chk("t6.ptr_ack", 64'(ack_vld), 64'h1);
    chk("t6.ptr_addr", 64'(f_addr), 64'h10);
    tick();
    clear_inputs();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
